food_vendor_n: RTL and testbench
================================

FOOD_VENDOR_N -- requirements
Module: food_vendor_n

Interface
REQ-001 SHALL have parameter N_ITEMS, default 4, number of selectable items.
REQ-002 SHALL have parameter CREDIT_W, default 4, width of coin, credit, price and change values.
REQ-003 SHALL have parameter STOCK_W, default 3, per-item stock counter width.
REQ-004 SHALL have parameter INIT_STOCK, default 3, stock loaded into every item at reset.
REQ-005 SHALL have port clk  in  1  single clock, all logic on rising edge.
REQ-006 SHALL have port rst  in  1  reset, synchronous and active-low.
REQ-007 SHALL have port coin_valid  in  1  coin present this cycle.
REQ-008 SHALL have port coin_val  in  CREDIT_W  coin value.
REQ-009 SHALL have port sel_valid  in  1  selection request.
REQ-010 SHALL have port sel  in  clog2(N_ITEMS)  selected item index.
REQ-011 SHALL have port cancel  in  1  refund request.
REQ-012 SHALL have port restock_valid / restock_item / restock_qty  in  1 / clog2(N_ITEMS) / STOCK_W  restock command.
REQ-013 SHALL have port vend_valid / vend_item  out  1 / clog2(N_ITEMS)  one-cycle dispense pulse and index.
REQ-014 SHALL have port change_valid / change_amt  out  1 / CREDIT_W  one-cycle change pulse and amount.
REQ-015 SHALL have port credit  out  CREDIT_W  current accumulated credit.
REQ-016 SHALL have port avail  out  N_ITEMS  bit i set when stock[i] nonzero.
REQ-017 SHALL have port coin_reject / err_soldout / err_funds  out  1 each  one-cycle error pulses.

Function
REQ-018 FSM states SHALL be IDLE (credit 0), CREDIT (credit >0), VEND, CHANGE.
REQ-019 Accepted coin in IDLE/CREDIT SHALL add coin_val to credit next cycle; state to CREDIT.
REQ-020 Coin making credit exceed 2^CREDIT_W-1, or arriving in VEND/CHANGE, SHALL be refused: credit unchanged, coin_reject pulses next cycle.
REQ-021 Same-cycle priority SHALL be cancel > sel_valid > coin_valid; lower-priority requests are dropped (dropped coin raises coin_reject).
REQ-022 sel_valid at cycle t with stock[sel]=0 SHALL pulse err_soldout at t+1, credit retained.
REQ-023 sel_valid at t with credit < PRICE[sel] SHALL pulse err_funds at t+1, credit retained.
REQ-024 Valid selection at t SHALL enter VEND: vend_valid=1, vend_item=sel, stock[sel] decremented, at t+1.
REQ-025 If credit-PRICE[sel] >0, CHANGE SHALL follow at t+2 with change_valid=1, change_amt=difference; credit 0 and IDLE at t+3. Zero difference SHALL return to IDLE at t+2 with no change pulse.
REQ-026 cancel in CREDIT SHALL pulse change_valid with full credit next cycle and clear credit; cancel in IDLE, VEND or CHANGE SHALL be ignored.
REQ-027 sel_valid with sel >= N_ITEMS SHALL be treated as sold out.
REQ-028 Restock SHALL be accepted only in IDLE; stock saturates at 2^STOCK_W-1; ignored otherwise.
REQ-029 avail SHALL be registered and reflect stock after the same edge's update.
REQ-030 All pulse outputs SHALL be high exactly one cycle; change_amt SHALL be 0 when change_valid is low.

Reset
REQ-031 rst low at a rising edge SHALL force IDLE, credit 0, every stock to INIT_STOCK (saturated), all pulses 0, avail all ones when INIT_STOCK>0.
REQ-032 Reset mid-VEND/CHANGE SHALL abort without issuing pending vend/change pulses; credit is lost.

Structure
REQ-033 A shared package SHALL hold the FSM state enum and the PRICE table (defaults 2,3,5,7 for items 0..3).
REQ-034 Per-item stock counters SHALL be one sub-module, stock_bank, instantiated once with N_ITEMS counters.

Verification
REQ-035 Coins 2,3 then sel=1 -> credit 5; vend_valid item1 next cycle; change 2 cycle after; credit 0.
REQ-036 Coin 7, sel=3 -> vend item3, no change pulse, back to IDLE at t+2.
REQ-037 Sel item0 four times with exact credit 2 each -> three vends; fourth gives err_soldout; avail[0]=0.
REQ-038 Credit 3, sel=2 -> err_funds; then cancel -> change_valid, change_amt 3, credit 0.
REQ-039 Credit 12, coin 7 -> coin_reject, credit stays 12; cancel+sel same cycle -> refund 12, no vend.
REQ-040 rst low during VEND -> no change pulse; credit 0, all stock 3; restock item0 qty 6 -> stock saturates 7.

Source files
------------

// File: rtl/food_vendor_n_pkg.sv
// Shared types and price table for the food vendor.
package food_vendor_n_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CREDIT,
    ST_VEND,
    ST_CHANGE
  } state_e;

  localparam int unsigned PRICE_LEN = 4;

  // Item prices, element i is the price of item i.
  localparam logic [PRICE_LEN-1:0][7:0] PRICE = {8'd7, 8'd5, 8'd3, 8'd2};

  // Items beyond the table reuse the last entry.
  function automatic logic [7:0] item_price(input logic [7:0] idx);
    if (idx < 8'(PRICE_LEN)) begin
      return PRICE[idx[1:0]];
    end
    return PRICE[PRICE_LEN-1];
  endfunction

endpackage

// File: rtl/food_vendor_n_stock_bank.sv
// Per-item stock counters with decrement on vend and saturating restock.
module stock_bank #(
  parameter int unsigned N_ITEMS    = 4,
  parameter int unsigned STOCK_W    = 3,
  parameter int unsigned INIT_STOCK = 3,
  parameter int unsigned SEL_W      = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               dec_en,
  input  logic [SEL_W-1:0]   dec_idx,
  input  logic               inc_en,
  input  logic [SEL_W-1:0]   inc_idx,
  input  logic [STOCK_W-1:0] inc_qty,
  output logic [N_ITEMS-1:0] avail
);

  localparam int unsigned SMAX     = (1 << STOCK_W) - 1;
  localparam int unsigned INIT_SAT = (INIT_STOCK > SMAX) ? SMAX : INIT_STOCK;
  localparam logic [STOCK_W-1:0] INIT_V = STOCK_W'(INIT_SAT);

  logic [STOCK_W-1:0] stock_q   [N_ITEMS];
  logic [STOCK_W-1:0] stock_d   [N_ITEMS];
  logic [STOCK_W-1:0] stock_dec [N_ITEMS];
  logic [STOCK_W:0]   stock_sum [N_ITEMS];
  logic [N_ITEMS-1:0] avail_q;
  logic [N_ITEMS-1:0] avail_d;

  // Next stock: decrement first, then saturating restock add; avail follows new stock.
  always_comb begin
    for (int unsigned i = 0; i < N_ITEMS; i++) begin
      stock_dec[i] = stock_q[i];
      if (dec_en && (dec_idx == SEL_W'(i)) && (stock_q[i] != '0)) begin
        stock_dec[i] = stock_q[i] - 1'b1;
      end
      stock_sum[i] = {1'b0, stock_dec[i]} + {1'b0, inc_qty};
      stock_d[i]   = stock_dec[i];
      if (inc_en && (inc_idx == SEL_W'(i))) begin
        stock_d[i] = stock_sum[i][STOCK_W] ? '1 : stock_sum[i][STOCK_W-1:0];
      end
      avail_d[i] = (stock_d[i] != '0);
    end
  end

  // Stock and availability registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < N_ITEMS; i++) begin
        stock_q[i] <= INIT_V;
      end
      avail_q <= (INIT_SAT != 0) ? '1 : '0;
    end else begin
      for (int unsigned i = 0; i < N_ITEMS; i++) begin
        stock_q[i] <= stock_d[i];
      end
      avail_q <= avail_d;
    end
  end

  assign avail = avail_q;

endmodule

// File: rtl/food_vendor_n.sv
// Coin-operated vending controller: credit, selection, dispense and change.
module food_vendor_n
  import food_vendor_n_pkg::*;
#(
  parameter int unsigned N_ITEMS    = 4,
  parameter int unsigned CREDIT_W   = 4,
  parameter int unsigned STOCK_W    = 3,
  parameter int unsigned INIT_STOCK = 3,
  localparam int unsigned SEL_W     = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_valid,
  input  logic [CREDIT_W-1:0] coin_val,
  input  logic                sel_valid,
  input  logic [SEL_W-1:0]    sel,
  input  logic                cancel,
  input  logic                restock_valid,
  input  logic [SEL_W-1:0]    restock_item,
  input  logic [STOCK_W-1:0]  restock_qty,
  output logic                vend_valid,
  output logic [SEL_W-1:0]    vend_item,
  output logic                change_valid,
  output logic [CREDIT_W-1:0] change_amt,
  output logic [CREDIT_W-1:0] credit,
  output logic [N_ITEMS-1:0]  avail,
  output logic                coin_reject,
  output logic                err_soldout,
  output logic                err_funds
);

  localparam int unsigned AW = ((CREDIT_W > 8) ? CREDIT_W : 8) + 1;

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                vend_valid_q, vend_valid_d;
  logic [SEL_W-1:0]    vend_item_q, vend_item_d;
  logic                change_valid_q, change_valid_d;
  logic [CREDIT_W-1:0] change_amt_q, change_amt_d;
  logic                coin_reject_q, coin_reject_d;
  logic                err_soldout_q, err_soldout_d;
  logic                err_funds_q, err_funds_d;

  logic                dec_en;
  logic                inc_en;
  logic                sel_oob;
  logic                sel_in_stock;
  logic [AW-1:0]       price_ext;
  logic [AW-1:0]       credit_ext;
  logic [AW-1:0]       remain_ext;
  logic [CREDIT_W:0]   coin_sum;

  stock_bank #(
    .N_ITEMS    (N_ITEMS),
    .STOCK_W    (STOCK_W),
    .INIT_STOCK (INIT_STOCK),
    .SEL_W      (SEL_W)
  ) u_stock_bank (
    .clk     (clk),
    .rst     (rst),
    .dec_en  (dec_en),
    .dec_idx (sel),
    .inc_en  (inc_en),
    .inc_idx (restock_item),
    .inc_qty (restock_qty),
    .avail   (avail)
  );

  // Selection qualification and credit arithmetic shared by the FSM.
  always_comb begin
    sel_oob      = (int'(sel) >= int'(N_ITEMS));
    sel_in_stock = !sel_oob && avail[sel];
    price_ext    = AW'(item_price(8'(sel)));
    credit_ext   = AW'(credit_q);
    remain_ext   = credit_ext - price_ext;
    coin_sum     = {1'b0, credit_q} + {1'b0, coin_val};
  end

  // FSM next state, credit and pulse outputs; cancel > select > coin.
  always_comb begin
    state_d        = state_q;
    credit_d       = credit_q;
    vend_valid_d   = 1'b0;
    vend_item_d    = vend_item_q;
    change_valid_d = 1'b0;
    change_amt_d   = '0;
    coin_reject_d  = 1'b0;
    err_soldout_d  = 1'b0;
    err_funds_d    = 1'b0;
    dec_en         = 1'b0;
    inc_en         = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_CREDIT: begin
        inc_en = restock_valid && (state_q == ST_IDLE);
        if (cancel && (state_q == ST_CREDIT)) begin
          change_valid_d = 1'b1;
          change_amt_d   = credit_q;
          credit_d       = '0;
          coin_reject_d  = coin_valid;
          state_d        = ST_IDLE;
        end else if (sel_valid) begin
          coin_reject_d = coin_valid;
          if (!sel_in_stock) begin
            err_soldout_d = 1'b1;
          end else if (credit_ext < price_ext) begin
            err_funds_d = 1'b1;
          end else begin
            vend_valid_d = 1'b1;
            vend_item_d  = sel;
            dec_en       = 1'b1;
            credit_d     = CREDIT_W'(remain_ext);
            state_d      = ST_VEND;
          end
        end else if (coin_valid) begin
          if (coin_sum[CREDIT_W]) begin
            coin_reject_d = 1'b1;
          end else begin
            credit_d = coin_sum[CREDIT_W-1:0];
            state_d  = (coin_sum != '0) ? ST_CREDIT : state_q;
          end
        end
      end
      ST_VEND: begin
        // Credit already holds the remainder after the price was deducted.
        coin_reject_d = coin_valid;
        if (credit_q != '0) begin
          change_valid_d = 1'b1;
          change_amt_d   = credit_q;
          state_d        = ST_CHANGE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CHANGE: begin
        coin_reject_d = coin_valid;
        credit_d      = '0;
        state_d       = ST_IDLE;
      end
      default: begin
        credit_d = '0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      credit_q       <= '0;
      vend_valid_q   <= 1'b0;
      vend_item_q    <= '0;
      change_valid_q <= 1'b0;
      change_amt_q   <= '0;
      coin_reject_q  <= 1'b0;
      err_soldout_q  <= 1'b0;
      err_funds_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      credit_q       <= credit_d;
      vend_valid_q   <= vend_valid_d;
      vend_item_q    <= vend_item_d;
      change_valid_q <= change_valid_d;
      change_amt_q   <= change_amt_d;
      coin_reject_q  <= coin_reject_d;
      err_soldout_q  <= err_soldout_d;
      err_funds_q    <= err_funds_d;
    end
  end

  assign vend_valid   = vend_valid_q;
  assign vend_item    = vend_item_q;
  assign change_valid = change_valid_q;
  assign change_amt   = change_amt_q;
  assign credit       = credit_q;
  assign coin_reject  = coin_reject_q;
  assign err_soldout  = err_soldout_q;
  assign err_funds    = err_funds_q;

endmodule

// File: tb/tb_food_vendor_n.sv
// Self-checking bench for food_vendor_n: directed scenarios then random traffic.
module tb_food_vendor_n;

  localparam int N    = 4;
  localparam int CMAX = 15;
  localparam int SMAX = 7;

  logic       clk = 1'b0;
  logic       rst;
  logic       coin_valid;
  logic [3:0] coin_val;
  logic       sel_valid;
  logic [1:0] sel;
  logic       cancel;
  logic       restock_valid;
  logic [1:0] restock_item;
  logic [2:0] restock_qty;
  logic       vend_valid;
  logic [1:0] vend_item;
  logic       change_valid;
  logic [3:0] change_amt;
  logic [3:0] credit;
  logic [3:0] avail;
  logic       coin_reject;
  logic       err_soldout;
  logic       err_funds;

  always #5 clk = ~clk;

  food_vendor_n #(
    .N_ITEMS    (4),
    .CREDIT_W   (4),
    .STOCK_W    (3),
    .INIT_STOCK (3)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .coin_valid    (coin_valid),
    .coin_val      (coin_val),
    .sel_valid     (sel_valid),
    .sel           (sel),
    .cancel        (cancel),
    .restock_valid (restock_valid),
    .restock_item  (restock_item),
    .restock_qty   (restock_qty),
    .vend_valid    (vend_valid),
    .vend_item     (vend_item),
    .change_valid  (change_valid),
    .change_amt    (change_amt),
    .credit        (credit),
    .avail         (avail),
    .coin_reject   (coin_reject),
    .err_soldout   (err_soldout),
    .err_funds     (err_funds)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: credit, stock, and a countdown of post-vend cycles.
  int price_tab [N] = '{2, 3, 5, 7};
  int m_credit;
  int m_stock [N];
  int m_busy;      // 0: accepting, 1: dispensing, 2: returning change
  int m_change;    // change owed after the current dispense
  int e_vend, e_item, e_chg, e_amt, e_rej, e_sold, e_funds;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    int s;
    bool_idle: begin end
    e_vend = 0; e_item = 0; e_chg = 0; e_amt = 0; e_rej = 0; e_sold = 0; e_funds = 0;
    if (!rst) begin
      m_credit = 0; m_busy = 0; m_change = 0;
      for (int i = 0; i < N; i++) m_stock[i] = 3;
      return;
    end
    if (m_busy == 1) begin
      e_rej = int'(coin_valid);
      if (m_change > 0) begin
        e_chg = 1; e_amt = m_change; m_busy = 2;
      end else begin
        m_busy = 0; m_credit = 0;
      end
    end else if (m_busy == 2) begin
      e_rej = int'(coin_valid);
      m_busy = 0; m_credit = 0; m_change = 0;
    end else begin
      automatic bit was_idle = (m_credit == 0);
      if (cancel && m_credit > 0) begin
        e_chg = 1; e_amt = m_credit; m_credit = 0;
        e_rej = int'(coin_valid);
      end else if (sel_valid) begin
        e_rej = int'(coin_valid);
        s = int'(sel);
        if (s >= N || m_stock[s] == 0) e_sold = 1;
        else if (m_credit < price_tab[s]) e_funds = 1;
        else begin
          e_vend = 1; e_item = s;
          m_stock[s] = m_stock[s] - 1;
          m_change = m_credit - price_tab[s];
          m_credit = m_change;
          m_busy = 1;
        end
      end else if (coin_valid) begin
        if (m_credit + int'(coin_val) > CMAX) e_rej = 1;
        else m_credit = m_credit + int'(coin_val);
      end
      if (was_idle && restock_valid) begin
        s = int'(restock_item);
        m_stock[s] = m_stock[s] + int'(restock_qty);
        if (m_stock[s] > SMAX) m_stock[s] = SMAX;
      end
    end
  endtask

  // One clock: model predicts, DUT steps, outputs compared #1 after the edge.
  task automatic cyc();
    logic [3:0] exp_avail;
    model_step();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) exp_avail[i] = (m_stock[i] != 0);
    chk("vend_valid", 32'(vend_valid), 32'(e_vend));
    if (e_vend != 0) chk("vend_item", 32'(vend_item), 32'(e_item));
    chk("change_valid", 32'(change_valid), 32'(e_chg));
    chk("change_amt", 32'(change_amt), 32'(e_amt));
    chk("coin_reject", 32'(coin_reject), 32'(e_rej));
    chk("err_soldout", 32'(err_soldout), 32'(e_sold));
    chk("err_funds", 32'(err_funds), 32'(e_funds));
    chk("avail", 32'(avail), 32'(exp_avail));
    if (m_busy == 0) chk("credit", 32'(credit), 32'(m_credit));
    coin_valid = 0; sel_valid = 0; cancel = 0; restock_valid = 0;
  endtask

  task automatic coin(input int v);
    coin_valid = 1; coin_val = 4'(v); cyc();
  endtask

  task automatic pick(input int s);
    sel_valid = 1; sel = 2'(s); cyc();
  endtask

  initial begin
    rst = 0; coin_valid = 0; coin_val = 0; sel_valid = 0; sel = 0; cancel = 0;
    restock_valid = 0; restock_item = 0; restock_qty = 0;
    m_credit = 0; m_busy = 0; m_change = 0;
    for (int i = 0; i < N; i++) m_stock[i] = 3;

    cyc(); cyc();
    chk("rst_credit", 32'(credit), 32'd0);
    chk("rst_avail", 32'(avail), 32'hF);
    rst = 1;
    cyc();

    // Coins 2 and 3, select item 1: vend, then change 2, then credit 0.
    coin(2); coin(3);
    chk("s1_credit", 32'(credit), 32'd5);
    pick(1);
    chk("s1_vend", 32'(vend_valid), 32'd1);
    cyc();
    chk("s1_change", 32'(change_amt), 32'd2);
    cyc();
    chk("s1_credit0", 32'(credit), 32'd0);

    // Exact credit 7 for item 3: no change pulse.
    coin(7); pick(3);
    cyc();
    chk("s2_nochange", 32'(change_valid), 32'd0);

    // Item 0 four times at exact price: fourth is sold out.
    for (int k = 0; k < 4; k++) begin
      coin(2); pick(0); cyc();
    end
    chk("s3_avail0", 32'(avail[0]), 32'd0);
    cancel = 1; cyc();

    // Insufficient funds, then refund.
    coin(3); pick(2);
    cancel = 1; cyc();
    chk("s4_refund", 32'(change_amt), 32'd3);

    // Overflowing coin rejected; cancel wins over a same-cycle select.
    coin(7); coin(5); coin(7);
    chk("s5_credit", 32'(credit), 32'd12);
    cancel = 1; sel_valid = 1; sel = 2'd1; cyc();
    chk("s5_refund", 32'(change_amt), 32'd12);

    // Reset while dispensing, then saturating restock of item 0.
    coin(7); coin(3); pick(3);
    rst = 0; cyc(); rst = 1;
    restock_valid = 1; restock_item = 0; restock_qty = 3'd6; cyc();
    for (int k = 0; k < 8; k++) begin
      coin(2); pick(0); cyc();
    end
    cancel = 1; cyc();

    // Random traffic.
    for (int k = 0; k < 600; k++) begin
      rst           = ($urandom_range(0, 63) != 0);
      coin_valid    = ($urandom_range(0, 2) == 0);
      coin_val      = 4'($urandom_range(0, 8));
      sel_valid     = ($urandom_range(0, 3) == 0);
      sel           = 2'($urandom_range(0, 3));
      cancel        = ($urandom_range(0, 7) == 0);
      restock_valid = ($urandom_range(0, 5) == 0);
      restock_item  = 2'($urandom_range(0, 3));
      restock_qty   = 3'($urandom_range(0, 7));
      if (cancel && m_busy == 0 && m_credit == 0) begin
        sel_valid = 0; coin_valid = 0;
      end
      cyc();
    end
    rst = 1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
